dsc_cache_rd_ctrl: RTL

Read-side controller for the descriptor cache SRAM (synchronous, registered-address plus registered-data read, latency RD_LATENCY).
- Accepts descriptor read requests over a valid/ready interface and drives the SRAM read port (REN/RADDR).
- Tracks in-flight reads and captures returning RDATA into a credit-protected response FIFO.
- Presents responses over a valid/ready interface, so a stalled consumer never loses SRAM data.
- Sits between the descriptor fetch engine and the cache RAM wrapper; the write side of the cache is owned elsewhere.

---
 rtl/dsc_cache_rd_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dsc_cache_rd_ctrl.sv
// Descriptor cache read controller: credit-limited SRAM reads into a show-ahead response FIFO.
// Optional ECC flag tracking and counters are enabled with `define DSC_RD_CTRL_ECC_EN.
module dsc_cache_rd_ctrl #(
  parameter int WIDTH      = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                              CLOCK,
  input  logic                              RESET,
  input  logic                              REQ_VALID,
  output logic                              REQ_READY,
  input  logic [ADDR_WIDTH-1:0]             REQ_ADDR,
  output logic                              REN,
  output logic [ADDR_WIDTH-1:0]             RADDR,
  input  logic [WIDTH-1:0]                  RDATA,
`ifdef DSC_RD_CTRL_ECC_EN
  input  logic                              SB_CORRECT,
  input  logic                              DB_DETECT,
`endif
  output logic                              RSP_VALID,
  input  logic                              RSP_READY,
  output logic [WIDTH-1:0]                  RSP_DATA,
  output logic [$clog2(BUF_DEPTH+1)-1:0]    OUTSTANDING,
`ifdef DSC_RD_CTRL_ECC_EN
  output logic                              RSP_SBE,
  output logic                              RSP_DBE,
  output logic [15:0]                       SBE_COUNT,
  output logic [15:0]                       DBE_COUNT,
`endif
  output logic                              BUSY
);

  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
`ifdef DSC_RD_CTRL_ECC_EN
  localparam int EW = WIDTH + 2;
`else
  localparam int EW = WIDTH;
`endif
  localparam logic [OW-1:0] DEPTH_C = OW'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(BUF_DEPTH - 1);

  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic [OW-1:0]         level_q, level_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]         mem_q [BUF_DEPTH];
  logic [EW-1:0]         wr_entry;
  logic [EW-1:0]         head;
  logic                  accept, capture, pop;

  // Credits cover both the latency pipe and the FIFO, so a capture always finds a free slot.
  assign REQ_READY   = (outst_q < DEPTH_C) & ~RESET;
  assign accept      = REQ_VALID & REQ_READY;
  assign REN         = accept;
  assign RADDR       = REQ_ADDR;
  assign capture     = pipe_q[RD_LATENCY-1];
  assign RSP_VALID   = (level_q != '0);
  assign pop         = RSP_VALID & RSP_READY;
  assign head        = mem_q[rd_ptr_q];
  assign RSP_DATA    = RSP_VALID ? head[WIDTH-1:0] : '0;
  assign OUTSTANDING = outst_q;
  assign BUSY        = (outst_q != '0);

`ifdef DSC_RD_CTRL_ECC_EN
  assign wr_entry = {SB_CORRECT, DB_DETECT, RDATA};
  assign RSP_SBE  = RSP_VALID & head[WIDTH+1];
  assign RSP_DBE  = RSP_VALID & head[WIDTH];
`else
  assign wr_entry = RDATA;
`endif

  always_comb begin
    pipe_d   = RD_LATENCY'({pipe_q, accept});
    outst_d  = outst_q;
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({accept, pop})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
    case ({capture, pop})
      2'b10:   level_d = level_q + OW'(1);
      2'b01:   level_d = level_q - OW'(1);
      default: level_d = level_q;
    endcase
    if (capture) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pipe_q   <= '0;
      outst_q  <= '0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pipe_q   <= pipe_d;
      outst_q  <= outst_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; validity comes entirely from level_q.
  always_ff @(posedge CLOCK) begin
    if (capture) mem_q[wr_ptr_q] <= wr_entry;
  end

`ifdef DSC_RD_CTRL_ECC_EN
  logic [15:0] sbe_cnt_q, dbe_cnt_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      if (pop && head[WIDTH+1] && (sbe_cnt_q != 16'hFFFF)) sbe_cnt_q <= sbe_cnt_q + 16'd1;
      if (pop && head[WIDTH]   && (dbe_cnt_q != 16'hFFFF)) dbe_cnt_q <= dbe_cnt_q + 16'd1;
    end
  end

  assign SBE_COUNT = sbe_cnt_q;
  assign DBE_COUNT = dbe_cnt_q;
`endif

endmodule
